// File: rtl/port_arbiter.sv
// ----------------------------------------------------------------------------
// port_arbiter
//
// Purpose:
//   Sequences access to one shared two-sided port between node A and node B.
//   Each node raises level-held write/read requests; the arbiter turns them
//   into port strobes that only ever form legal sequences:
//     write (EMPTY) -> read by the opposite side (HELD_x) -> CLEAR -> EMPTY
//   Simultaneous writes from EMPTY are arbitrated round-robin. Data read from
//   the port is captured into a per-node register with a one-cycle valid pulse.
//   A sticky err flag records any cycle where the port status disagrees with
//   the sequencer state, or the port raises panic.
//
// Parameters:
//   N        data width (must match the port)
//   TIMEOUT  hold-cycle limit (only used when PORT_ARB_TIMEOUT_EN is defined)
//
// Optional feature (macro PORT_ARB_TIMEOUT_EN):
//   Adds a counter of consecutive HELD_A/HELD_B cycles and a sticky timeout
//   output that rises when the count reaches TIMEOUT. Sequencing is unaffected.
//   With the macro undefined there is no counter and no timeout port.
//
// Ports:
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   a_req_write, a_wdata    A write request (held until a_wr_ack) and its data
//   a_req_read              A read request (held until a_rd_valid)
//   a_wr_ack                pulse: A's write was issued to the port
//   a_rd_valid, a_rd_data   pulse: a_rd_data updated / last value received by A
//   b_*                     same set for node B
//   a_write, a_out, a_read  strobes and write data to port side A
//   b_write, b_out, b_read  strobes and write data to port side B
//   a_in, b_in              port read data for side A / side B
//   a_blocked, b_blocked    port status: side holds an unread value
//   panic                   port status: fault
//   err                     sticky fault flag
//   timeout                 sticky hold timeout (PORT_ARB_TIMEOUT_EN only)
// ----------------------------------------------------------------------------
module port_arbiter #(
    parameter int N       = 8,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset_n,

    // node A
    input  logic         a_req_write,
    input  logic [N-1:0] a_wdata,
    input  logic         a_req_read,
    output logic         a_wr_ack,
    output logic         a_rd_valid,
    output logic [N-1:0] a_rd_data,

    // node B
    input  logic         b_req_write,
    input  logic [N-1:0] b_wdata,
    input  logic         b_req_read,
    output logic         b_wr_ack,
    output logic         b_rd_valid,
    output logic [N-1:0] b_rd_data,

    // port side A
    output logic         a_write,
    output logic [N-1:0] a_out,
    output logic         a_read,
    input  logic [N-1:0] a_in,

    // port side B
    output logic         b_write,
    output logic [N-1:0] b_out,
    output logic         b_read,
    input  logic [N-1:0] b_in,

    // port status
    input  logic         a_blocked,
    input  logic         b_blocked,
    input  logic         panic,

    output logic         err
`ifdef PORT_ARB_TIMEOUT_EN
    ,
    output logic         timeout
`endif
);

    // Elaboration-time sanity check on the configuration.
    if (N < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("port_arbiter: N and TIMEOUT must both be at least 1");
    end

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        HELD_A = 2'd1,   // A has written; waiting for B to read
        HELD_B = 2'd2,   // B has written; waiting for A to read
        CLEAR  = 2'd3    // one idle cycle while the port clears after a read
    } state_t;

    state_t st_reg, st_next;
    logic   rr_reg, rr_next;      // 0: A wins a tie, 1: B wins a tie
    logic   err_reg;

    // Per-side views: index 0 = A, 1 = B.
    logic [1:0]        req_write;
    logic [1:0]        req_read;
    logic [1:0]        grant;        // write strobe + ack, before reset gating
    logic [1:0]        rd_strobe;    // read strobe, before reset gating
    logic [1:0][N-1:0] wdata_arr;
    logic [1:0][N-1:0] port_in;
    logic [1:0][N-1:0] out_arr;
    logic [1:0][N-1:0] rd_data_reg;
    logic [1:0]        rd_valid_reg;
    logic              err_cond;

    assign req_write = {b_req_write, a_req_write};
    assign req_read  = {b_req_read,  a_req_read};
    assign wdata_arr = {b_wdata,     a_wdata};
    assign port_in   = {b_in,        a_in};

    // ------------------------------------------------------------------------
    // Next-state / strobe decode
    // ------------------------------------------------------------------------
    always_comb begin
        st_next   = st_reg;
        rr_next   = rr_reg;
        grant     = 2'b00;
        rd_strobe = 2'b00;

        case (st_reg)
            EMPTY: begin
                // Reads are meaningless here: the port holds nothing.
                if (req_write[0] && req_write[1]) begin
                    grant = rr_reg ? 2'b10 : 2'b01;
                end else begin
                    grant = req_write;
                end

                if (grant[0]) begin
                    st_next = HELD_A;
                    rr_next = 1'b1;
                end else if (grant[1]) begin
                    st_next = HELD_B;
                    rr_next = 1'b0;
                end
            end

            HELD_A: begin
                // Only the opposite side may read; every other request waits.
                if (req_read[1]) begin
                    rd_strobe[1] = 1'b1;
                    st_next      = CLEAR;
                end
            end

            HELD_B: begin
                if (req_read[0]) begin
                    rd_strobe[0] = 1'b1;
                    st_next      = CLEAR;
                end
            end

            CLEAR: begin
                st_next = EMPTY;
            end

            default: begin
                st_next = EMPTY;
            end
        endcase
    end

    // Fault conditions are judged against the state the port should be in
    // this cycle, i.e. the registered state.
    always_comb begin
        err_cond = panic;
        case (st_reg)
            HELD_A:  err_cond = err_cond | ~a_blocked;
            HELD_B:  err_cond = err_cond | ~b_blocked;
            EMPTY:   err_cond = err_cond | a_blocked | b_blocked;
            default: err_cond = err_cond;
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_reg  <= EMPTY;
            rr_reg  <= 1'b0;
            err_reg <= 1'b0;
        end else begin
            st_reg  <= st_next;
            rr_reg  <= rr_next;
            err_reg <= err_reg | err_cond;
        end
    end

    // ------------------------------------------------------------------------
    // Per-side write data muxing and read capture
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_side
            // The port only sees data while its write strobe is live.
            assign out_arr[gi] = (grant[gi] && reset_n) ? wdata_arr[gi] : '0;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    rd_data_reg[gi]  <= '0;
                    rd_valid_reg[gi] <= 1'b0;
                end else begin
                    rd_valid_reg[gi] <= rd_strobe[gi];
                    if (rd_strobe[gi]) begin
                        rd_data_reg[gi] <= port_in[gi];
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Outputs: strobes and acks are combinational but forced low in reset so
    // nothing is issued or acknowledged across a reset.
    // ------------------------------------------------------------------------
    assign a_write    = grant[0] & reset_n;
    assign a_wr_ack   = grant[0] & reset_n;
    assign a_read     = rd_strobe[0] & reset_n;
    assign a_out      = out_arr[0];

    assign b_write    = grant[1] & reset_n;
    assign b_wr_ack   = grant[1] & reset_n;
    assign b_read     = rd_strobe[1] & reset_n;
    assign b_out      = out_arr[1];

    assign a_rd_valid = rd_valid_reg[0];
    assign a_rd_data  = rd_data_reg[0];
    assign b_rd_valid = rd_valid_reg[1];
    assign b_rd_data  = rd_data_reg[1];

    assign err        = err_reg;

`ifdef PORT_ARB_TIMEOUT_EN
    // ------------------------------------------------------------------------
    // Hold timeout: the counter tracks the state being entered, so during the
    // k-th consecutive held cycle it reads k and timeout is already up on the
    // TIMEOUT-th held cycle. It saturates so it cannot wrap back below TIMEOUT.
    // ------------------------------------------------------------------------
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

    logic [TO_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic            timeout_reg;
    logic            held_next;

    assign held_next = (st_next == HELD_A) || (st_next == HELD_B);

    always_comb begin
        hold_cnt_next = '0;
        if (held_next) begin
            hold_cnt_next = (hold_cnt_reg == TO_MAX) ? TO_MAX : hold_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            hold_cnt_reg <= hold_cnt_next;
            if (hold_cnt_next == TO_MAX) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    assign timeout = timeout_reg;
`endif

endmodule

// File: tb/tb_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_port_arbiter
//
// Directed bench for port_arbiter. A cycle-by-cycle vector table covers
// write/read/CLEAR sequencing, round-robin ties, deferred re-requests and
// ignored reads. Hand-written sequences cover panic -> sticky err, reset in
// the middle of a hold, and (with PORT_ARB_TIMEOUT_EN) the hold timeout.
// A small behavioural port supplies a_in/b_in and the blocked flags, with a
// one-cycle delayed clear after a read.
// ----------------------------------------------------------------------------
module tb_port_arbiter;

    localparam int N = 8;

    logic         clk;
    logic         reset_n;
    logic         a_req_write, a_req_read, b_req_write, b_req_read;
    logic [N-1:0] a_wdata, b_wdata;
    logic         a_wr_ack, a_rd_valid, b_wr_ack, b_rd_valid;
    logic [N-1:0] a_rd_data, b_rd_data;
    logic         a_write, a_read, b_write, b_read;
    logic [N-1:0] a_out, b_out, a_in, b_in;
    logic         a_blocked, b_blocked, panic;
    logic         err;
`ifdef PORT_ARB_TIMEOUT_EN
    logic         timeout;
`endif

    int vectors;
    int miscompares;

    port_arbiter #(
        .N       (N),
`ifdef PORT_ARB_TIMEOUT_EN
        .TIMEOUT (4)
`else
        .TIMEOUT (255)
`endif
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .a_req_write (a_req_write),
        .a_wdata     (a_wdata),
        .a_req_read  (a_req_read),
        .a_wr_ack    (a_wr_ack),
        .a_rd_valid  (a_rd_valid),
        .a_rd_data   (a_rd_data),
        .b_req_write (b_req_write),
        .b_wdata     (b_wdata),
        .b_req_read  (b_req_read),
        .b_wr_ack    (b_wr_ack),
        .b_rd_valid  (b_rd_valid),
        .b_rd_data   (b_rd_data),
        .a_write     (a_write),
        .a_out       (a_out),
        .a_read      (a_read),
        .a_in        (a_in),
        .b_write     (b_write),
        .b_out       (b_out),
        .b_read      (b_read),
        .b_in        (b_in),
        .a_blocked   (a_blocked),
        .b_blocked   (b_blocked),
        .panic       (panic),
        .err         (err)
`ifdef PORT_ARB_TIMEOUT_EN
        ,
        .timeout     (timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural shared port ----------------
    logic [N-1:0] port_data;
    logic         a_clr_pend, b_clr_pend;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            port_data  <= '0;
            a_blocked  <= 1'b0;
            b_blocked  <= 1'b0;
            a_clr_pend <= 1'b0;
            b_clr_pend <= 1'b0;
        end else begin
            a_clr_pend <= b_read;
            b_clr_pend <= a_read;
            if (a_clr_pend) a_blocked <= 1'b0;
            if (b_clr_pend) b_blocked <= 1'b0;
            if (a_write) begin
                port_data <= a_out;
                a_blocked <= 1'b1;
            end
            if (b_write) begin
                port_data <= b_out;
                b_blocked <= 1'b1;
            end
        end
    end

    assign a_in = port_data;
    assign b_in = port_data;

    // ---------------- vector table ----------------
    typedef struct {
        logic         awr;  logic [N-1:0] awd;  logic ard;
        logic         bwr;  logic [N-1:0] bwd;  logic brd;
        logic         e_aw; logic [N-1:0] e_aout; logic e_ar;
        logic         e_bw; logic [N-1:0] e_bout; logic e_br;
        logic         e_av; logic [N-1:0] e_ad;
        logic         e_bv; logic [N-1:0] e_bd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic awr, input logic [N-1:0] awd, input logic ard,
        input logic bwr, input logic [N-1:0] bwd, input logic brd,
        input logic e_aw, input logic [N-1:0] e_aout, input logic e_ar,
        input logic e_bw, input logic [N-1:0] e_bout, input logic e_br,
        input logic e_av, input logic [N-1:0] e_ad,
        input logic e_bv, input logic [N-1:0] e_bd);
        vec_t v;
        v.awr = awr;   v.awd = awd;       v.ard = ard;
        v.bwr = bwr;   v.bwd = bwd;       v.brd = brd;
        v.e_aw = e_aw; v.e_aout = e_aout; v.e_ar = e_ar;
        v.e_bw = e_bw; v.e_bout = e_bout; v.e_br = e_br;
        v.e_av = e_av; v.e_ad = e_ad;
        v.e_bv = e_bv; v.e_bd = e_bd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        a_req_write = 1'b0; a_wdata = '0; a_req_read = 1'b0;
        b_req_write = 1'b0; b_wdata = '0; b_req_read = 1'b0;
        panic = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        // Cycle-by-cycle expectations, starting from EMPTY with rr = 0.
        //          A: wr  wdata rd  B: wr  wdata rd | aw aout  ar  bw bout  br  av ad    bv bd
        tbl.push_back(mk(1, 8'h11, 0, 1, 8'h22, 0,   1, 8'h11, 0, 0, 8'h00, 0,  0, 8'h00, 0, 8'h00)); // tie -> A
        tbl.push_back(mk(0, 8'h00, 0, 1, 8'h22, 1,   0, 8'h00, 0, 0, 8'h00, 1,  0, 8'h00, 0, 8'h00)); // B reads, write waits
        tbl.push_back(mk(0, 8'h00, 0, 1, 8'h22, 1,   0, 8'h00, 0, 0, 8'h00, 0,  0, 8'h00, 1, 8'h11)); // CLEAR, valid
        tbl.push_back(mk(0, 8'h00, 0, 1, 8'h22, 0,   0, 8'h00, 0, 1, 8'h22, 0,  0, 8'h00, 0, 8'h11)); // B granted
        tbl.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0,   0, 8'h00, 1, 0, 8'h00, 0,  0, 8'h00, 0, 8'h11)); // A reads
        tbl.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0,   0, 8'h00, 0, 0, 8'h00, 0,  1, 8'h22, 0, 8'h11)); // CLEAR
        tbl.push_back(mk(1, 8'h5A, 0, 0, 8'h00, 0,   1, 8'h5A, 0, 0, 8'h00, 0,  0, 8'h22, 0, 8'h11)); // A alone
        tbl.push_back(mk(1, 8'h33, 0, 0, 8'h00, 1,   0, 8'h00, 0, 0, 8'h00, 1,  0, 8'h22, 0, 8'h11)); // re-request held off
        tbl.push_back(mk(1, 8'h33, 0, 0, 8'h00, 1,   0, 8'h00, 0, 0, 8'h00, 0,  0, 8'h22, 1, 8'h5A)); // CLEAR, no write
        tbl.push_back(mk(1, 8'h33, 0, 0, 8'h00, 0,   1, 8'h33, 0, 0, 8'h00, 0,  0, 8'h22, 0, 8'h5A)); // granted after CLEAR
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 1,   0, 8'h00, 0, 0, 8'h00, 1,  0, 8'h22, 0, 8'h5A));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 1,   0, 8'h00, 0, 0, 8'h00, 0,  0, 8'h22, 1, 8'h33));
        tbl.push_back(mk(1, 8'h66, 0, 1, 8'h77, 0,   0, 8'h00, 0, 1, 8'h77, 0,  0, 8'h22, 0, 8'h33)); // tie, rr=1 -> B
        tbl.push_back(mk(1, 8'h66, 1, 0, 8'h00, 0,   0, 8'h00, 1, 0, 8'h00, 0,  0, 8'h22, 0, 8'h33));
        tbl.push_back(mk(1, 8'h66, 1, 0, 8'h00, 0,   0, 8'h00, 0, 0, 8'h00, 0,  1, 8'h77, 0, 8'h33));
        tbl.push_back(mk(1, 8'h66, 0, 0, 8'h00, 0,   1, 8'h66, 0, 0, 8'h00, 0,  0, 8'h77, 0, 8'h33)); // A granted
        for (int i = 0; i < 10; i++)  // self-read while HELD_A: ignored
            tbl.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h77, 0, 8'h33));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 1,   0, 8'h00, 0, 0, 8'h00, 1,  0, 8'h77, 0, 8'h33));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 1,   0, 8'h00, 0, 0, 8'h00, 0,  0, 8'h77, 1, 8'h66));
        for (int i = 0; i < 3; i++)   // read in EMPTY: ignored
            tbl.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h77, 0, 8'h66));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0,   0, 8'h00, 0, 0, 8'h00, 0,  0, 8'h77, 0, 8'h66));

        // ---------------- reset ----------------
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset a_write",   a_write,   1'b0);
        check("reset b_write",   b_write,   1'b0);
        check("reset a_rd_data", a_rd_data, 8'h00);
        check("reset b_rd_data", b_rd_data, 8'h00);
        check("reset rd_valid",  {a_rd_valid, b_rd_valid}, 2'b00);
        check("reset err",       err,       1'b0);
        reset_n = 1'b1;

        // ---------------- table ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            a_req_write = tbl[i].awr; a_wdata = tbl[i].awd; a_req_read = tbl[i].ard;
            b_req_write = tbl[i].bwr; b_wdata = tbl[i].bwd; b_req_read = tbl[i].brd;
            @(negedge clk);
            check($sformatf("v%0d a_write", i),    a_write,    tbl[i].e_aw);
            check($sformatf("v%0d a_wr_ack", i),   a_wr_ack,   tbl[i].e_aw);
            check($sformatf("v%0d a_out", i),      a_out,      tbl[i].e_aout);
            check($sformatf("v%0d a_read", i),     a_read,     tbl[i].e_ar);
            check($sformatf("v%0d b_write", i),    b_write,    tbl[i].e_bw);
            check($sformatf("v%0d b_wr_ack", i),   b_wr_ack,   tbl[i].e_bw);
            check($sformatf("v%0d b_out", i),      b_out,      tbl[i].e_bout);
            check($sformatf("v%0d b_read", i),     b_read,     tbl[i].e_br);
            check($sformatf("v%0d a_rd_valid", i), a_rd_valid, tbl[i].e_av);
            check($sformatf("v%0d a_rd_data", i),  a_rd_data,  tbl[i].e_ad);
            check($sformatf("v%0d b_rd_valid", i), b_rd_valid, tbl[i].e_bv);
            check($sformatf("v%0d b_rd_data", i),  b_rd_data,  tbl[i].e_bd);
            check($sformatf("v%0d err", i),        err,        1'b0);
            $display("vector %0d: a_wr=%0b b_wr=%0b a_rd=%0b b_rd=%0b a_rd_data=%0h b_rd_data=%0h",
                     i, a_write, b_write, a_read, b_read, a_rd_data, b_rd_data);
            @(posedge clk);
            #1;
        end

        // ---------------- panic -> sticky err ----------------
        idle_inputs();
        panic = 1'b1;
        @(negedge clk);
        check("panic err not yet", err, 1'b0);
        @(posedge clk);
        #1;
        panic = 1'b0;
        @(negedge clk);
        check("panic err set", err, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("panic err sticky", err, 1'b1);
        $display("panic sequence: err=%0b", err);
        @(posedge clk);
        #1;

        // ---------------- reset during HELD_B ----------------
        b_req_write = 1'b1; b_wdata = 8'h99;
        @(negedge clk);
        check("rst seq b_write", b_write, 1'b1);
        @(posedge clk);
        #1;
        b_req_write = 1'b0; b_wdata = '0;
        a_req_read  = 1'b1;
        a_req_write = 1'b1; a_wdata = 8'h01;
        #1;
        check("rst seq a_read before", a_read, 1'b1);
        check("rst seq a_write held off", a_write, 1'b0);
        reset_n = 1'b0;
        #1;
        check("rst seq a_read forced", a_read, 1'b0);
        check("rst seq a_write forced", a_write, 1'b0);
        check("rst seq a_wr_ack forced", a_wr_ack, 1'b0);
        check("rst seq a_rd_data", a_rd_data, 8'h00);
        check("rst seq b_rd_data", b_rd_data, 8'h00);
        check("rst seq err cleared", err, 1'b0);
        @(posedge clk);
        #1;
        check("rst seq ack in reset", a_wr_ack, 1'b0);
        a_req_read = 1'b0;
        reset_n    = 1'b1;
        #1;
        check("post-rst a_write", a_write, 1'b1);
        check("post-rst a_wr_ack", a_wr_ack, 1'b1);
        check("post-rst a_out", a_out, 8'h01);
        $display("reset sequence: a_write=%0b a_out=%0h", a_write, a_out);
        @(posedge clk);
        #1;
        a_req_write = 1'b0; a_wdata = '0;

        // ---------------- hold with nobody reading ----------------
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
`ifdef PORT_ARB_TIMEOUT_EN
            check($sformatf("held %0d timeout", k), timeout, (k >= 4) ? 1'b1 : 1'b0);
`endif
            check($sformatf("held %0d err", k), err, 1'b0);
            check($sformatf("held %0d no strobes", k), {a_write, b_write, a_read, b_read}, 4'b0000);
            $display("held cycle %0d: err=%0b", k, err);
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
